// File: rtl/register_bank_pkg.sv
// Shared types and default sizes for the multi-port register bank.
// Imported by the bank top, its scoreboard and its bus interface users.
package register_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_BITS      = 32;
    localparam int DEF_ADDR_BITS      = 5;
    localparam int DEF_NUM_READ_PORTS = 2;

endpackage

// File: rtl/register_bank_if.sv
// Bus bundle for the register bank: write, read, reserve, clear, debug.
// The master drives requests; the slave (bank) returns data and status.
interface register_bank_if #(
    parameter int INSTRUCTION_BITSIZE = 32,
    parameter int REGISTER_ADDR_BITS  = 5,
    parameter int NUM_READ_PORTS      = 2
);
    localparam int DW = INSTRUCTION_BITSIZE;
    localparam int AW = REGISTER_ADDR_BITS;
    localparam int NP = NUM_READ_PORTS;

    logic                 wr0_en;
    logic [AW-1:0]        wr0_addr;
    logic [DW-1:0]        wr0_data;
    logic                 wr1_en;
    logic [AW-1:0]        wr1_addr;
    logic [DW-1:0]        wr1_data;
    logic [NP*AW-1:0]     rd_addr;
    logic [NP*DW-1:0]     rd_data;
    logic [NP-1:0]        rd_pending;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic                 clear_req;
    logic                 clear_busy;
    logic [AW-1:0]        register_data_debug_address;
    logic [DW-1:0]        register_data_debug;

    modport master (
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output rd_addr, rsv_en, rsv_addr, clear_req,
        output register_data_debug_address,
        input  rd_data, rd_pending, clear_busy, register_data_debug
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  rd_addr, rsv_en, rsv_addr, clear_req,
        input  register_data_debug_address,
        output rd_data, rd_pending, clear_busy, register_data_debug
    );

endinterface

// File: rtl/register_bank_scoreboard.sv
// Pending-producer bits per register with per-read-port lookup.
// A reservation in the same cycle as a write keeps the bit set.
module register_bank_scoreboard
    import register_bank_pkg::*;
#(
    parameter int REGISTER_ADDR_BITS = DEF_ADDR_BITS,
    parameter int NUM_READ_PORTS     = DEF_NUM_READ_PORTS
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_clr_en,
    input  logic [REGISTER_ADDR_BITS-1:0]          i_clr_addr,
    input  logic                                   i_set_en,
    input  logic [REGISTER_ADDR_BITS-1:0]          i_set_addr,
    input  logic                                   i_wr0_en,
    input  logic [REGISTER_ADDR_BITS-1:0]          i_wr0_addr,
    input  logic                                   i_wr1_en,
    input  logic [REGISTER_ADDR_BITS-1:0]          i_wr1_addr,
    input  logic [NUM_READ_PORTS*REGISTER_ADDR_BITS-1:0] i_rd_addr,
    output logic [NUM_READ_PORTS-1:0]              o_rd_pending
);
    localparam int AW    = REGISTER_ADDR_BITS;
    localparam int DEPTH = 2 ** AW;

    logic [DEPTH-1:0] r_pending;
    logic [AW-1:0]    w_addr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            if (i_clr_en)
                r_pending[i_clr_addr] <= 1'b0;
            if (i_wr0_en)
                r_pending[i_wr0_addr] <= 1'b0;
            if (i_wr1_en)
                r_pending[i_wr1_addr] <= 1'b0;
            // Last assignment wins: a new producer overrides the retiring write
            if (i_set_en && i_set_addr != '0)
                r_pending[i_set_addr] <= 1'b1;
        end
    end

    always_comb begin
        o_rd_pending = '0;
        w_addr       = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            w_addr = i_rd_addr[k*AW +: AW];
            o_rd_pending[k] = r_pending[w_addr]
                            && (w_addr != '0)
                            && !(i_wr0_en && i_wr0_addr == w_addr)
                            && !(i_wr1_en && i_wr1_addr == w_addr);
        end
    end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank with write-first bypass, scoreboard and
// a sequential clear engine that walks registers 1..DEPTH-1.
module register_bank_mp
    import register_bank_pkg::*;
#(
    parameter int INSTRUCTION_BITSIZE = DEF_DATA_BITS,
    parameter int REGISTER_ADDR_BITS  = DEF_ADDR_BITS,
    parameter int NUM_READ_PORTS      = DEF_NUM_READ_PORTS
) (
    input  logic          clk,
    input  logic          reset,
    register_bank_if.slave bus
);
    localparam int DW    = INSTRUCTION_BITSIZE;
    localparam int AW    = REGISTER_ADDR_BITS;
    localparam int NP    = NUM_READ_PORTS;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    r_regs [DEPTH];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic             w_idle;
    logic             w_wr0_en;
    logic             w_wr1_en;
    logic             w_rsv_en;
    logic [AW-1:0]    w_ra;
    logic [NP*DW-1:0] w_rd_data;

    assign w_idle   = (r_state == IDLE);
    assign w_wr0_en = bus.wr0_en && w_idle && (bus.wr0_addr != '0);
    assign w_wr1_en = bus.wr1_en && w_idle && (bus.wr1_addr != '0);
    assign w_rsv_en = bus.rsv_en && w_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (bus.clear_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                if (r_cnt == '1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else if (r_state == CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else begin
            if (w_wr0_en)
                r_regs[bus.wr0_addr] <= bus.wr0_data;
            if (w_wr1_en)
                r_regs[bus.wr1_addr] <= bus.wr1_data;
        end
    end

    // Write-first bypass; enables are already gated off during CLEAR
    always_comb begin
        w_rd_data = '0;
        w_ra      = '0;
        for (int k = 0; k < NP; k++) begin
            w_ra = bus.rd_addr[k*AW +: AW];
            if (w_ra == '0)
                w_rd_data[k*DW +: DW] = '0;
            else if (w_wr1_en && bus.wr1_addr == w_ra)
                w_rd_data[k*DW +: DW] = bus.wr1_data;
            else if (w_wr0_en && bus.wr0_addr == w_ra)
                w_rd_data[k*DW +: DW] = bus.wr0_data;
            else
                w_rd_data[k*DW +: DW] = r_regs[w_ra];
        end
    end

    assign bus.rd_data    = w_rd_data;
    assign bus.clear_busy = (r_state == CLEAR);
    assign bus.register_data_debug =
        (bus.register_data_debug_address == '0) ? '0 :
        r_regs[bus.register_data_debug_address];

    register_bank_scoreboard #(
        .REGISTER_ADDR_BITS (AW),
        .NUM_READ_PORTS     (NP)
    ) u_sb (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_clr_en     (r_state == CLEAR),
        .i_clr_addr   (r_cnt),
        .i_set_en     (w_rsv_en),
        .i_set_addr   (bus.rsv_addr),
        .i_wr0_en     (w_wr0_en),
        .i_wr0_addr   (bus.wr0_addr),
        .i_wr1_en     (w_wr1_en),
        .i_wr1_addr   (bus.wr1_addr),
        .i_rd_addr    (bus.rd_addr),
        .o_rd_pending (bus.rd_pending)
    );

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: bypass, priority, scoreboard,
// clear sequence and reset abort, checked with immediate assertions.
module tb_register_bank_mp;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cnt;

    always #5 clk = ~clk;

    register_bank_if #(
        .INSTRUCTION_BITSIZE (32),
        .REGISTER_ADDR_BITS  (5),
        .NUM_READ_PORTS      (2)
    ) bus ();

    register_bank_mp #(
        .INSTRUCTION_BITSIZE (32),
        .REGISTER_ADDR_BITS  (5),
        .NUM_READ_PORTS      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.wr0_en    = 1'b0;
        bus.wr0_addr  = '0;
        bus.wr0_data  = '0;
        bus.wr1_en    = 1'b0;
        bus.wr1_addr  = '0;
        bus.wr1_data  = '0;
        bus.rsv_en    = 1'b0;
        bus.rsv_addr  = '0;
        bus.clear_req = 1'b0;
    endtask

    initial begin
        idle_bus();
        bus.rd_addr = {5'd3, 5'd5};
        bus.register_data_debug_address = 5'd5;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rd0", bus.rd_data[31:0], 32'h0);
        chk("rst_rd1", bus.rd_data[63:32], 32'h0);
        chk("rst_pend", {30'h0, bus.rd_pending}, 32'h0);
        chk("rst_busy", {31'h0, bus.clear_busy}, 32'h0);
        chk("rst_dbg", bus.register_data_debug, 32'h0);

        // Bypass on wr0, port 1 unaffected
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hA5A5A5A5;
        #1;
        chk("byp_rd0", bus.rd_data[31:0], 32'hA5A5A5A5);
        chk("byp_rd1", bus.rd_data[63:32], 32'h0);
        chk("byp_dbg_pre", bus.register_data_debug, 32'h0);
        tick();
        idle_bus();
        #1;
        chk("byp_dbg", bus.register_data_debug, 32'hA5A5A5A5);

        // Same-address collision: wr1 wins
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22;
        bus.rd_addr = {5'd5, 5'd7};
        #1;
        chk("pri_byp", bus.rd_data[31:0], 32'h22);
        chk("pri_rd1", bus.rd_data[63:32], 32'hA5A5A5A5);
        tick();
        idle_bus();
        bus.register_data_debug_address = 5'd7;
        #1;
        chk("pri_dbg", bus.register_data_debug, 32'h22);
        chk("pri_arr", bus.rd_data[31:0], 32'h22);

        // Register 0 stays zero
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFF;
        bus.rd_addr = {5'd0, 5'd0};
        #1;
        chk("r0_byp", bus.rd_data[31:0], 32'h0);
        tick();
        idle_bus();
        bus.register_data_debug_address = 5'd0;
        #1;
        chk("r0_rd1", bus.rd_data[63:32], 32'h0);
        chk("r0_dbg", bus.register_data_debug, 32'h0);

        // Scoreboard
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        bus.rd_addr = {5'd3, 5'd0};
        #1;
        chk("sb_same", {30'h0, bus.rd_pending}, 32'h0);
        tick();
        idle_bus();
        #1;
        chk("sb_set", {30'h0, bus.rd_pending}, 32'h2);
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h33;
        #1;
        chk("sb_wmask", {30'h0, bus.rd_pending}, 32'h0);
        chk("sb_wdata", bus.rd_data[63:32], 32'h33);
        tick();
        idle_bus();
        #1;
        chk("sb_clr", {30'h0, bus.rd_pending}, 32'h0);
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd3; bus.wr1_data = 32'h44;
        tick();
        idle_bus();
        bus.rd_addr = {5'd3, 5'd3};
        #1;
        chk("sb_rsvwin", {30'h0, bus.rd_pending}, 32'h3);
        chk("sb_rsvdat", bus.rd_data[63:32], 32'h44);
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        tick();
        idle_bus();
        bus.rd_addr = {5'd3, 5'd0};
        #1;
        chk("sb_r0", {30'h0, bus.rd_pending}, 32'h2);

        // Fill 1..31 then clear
        for (int i = 1; i < 32; i++) begin
            bus.wr0_en = 1'b1; bus.wr0_addr = 5'(i); bus.wr0_data = 32'(i);
            tick();
        end
        idle_bus();
        bus.register_data_debug_address = 5'd31;
        #1;
        chk("fill_31", bus.register_data_debug, 32'd31);
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        tick();
        idle_bus();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'hDEAD;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
        bus.rd_addr = {5'd3, 5'd9};
        #1;
        chk("clr_busy0", {31'h0, bus.clear_busy}, 32'h1);
        chk("clr_nobyp", bus.rd_data[31:0], 32'd9);
        cnt = 0;
        while (bus.clear_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        idle_bus();
        #1;
        chk("clr_len", 32'(cnt), 32'd31);
        for (int i = 1; i < 32; i++) begin
            bus.register_data_debug_address = 5'(i);
            #1;
            chk($sformatf("clr_reg%0d", i), bus.register_data_debug, 32'h0);
        end
        bus.rd_addr = {5'd4, 5'd3};
        #1;
        chk("clr_pend", {30'h0, bus.rd_pending}, 32'h0);

        // Reset aborts an in-flight clear
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd29; bus.wr0_data = 32'h29;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd30;
        tick();
        idle_bus();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.rd_addr = {5'd30, 5'd29};
        #1;
        chk("ab_busy", {31'h0, bus.clear_busy}, 32'h1);
        chk("ab_pend", {30'h0, bus.rd_pending}, 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.register_data_debug_address = 5'd29;
        #1;
        chk("ab_idle", {31'h0, bus.clear_busy}, 32'h0);
        chk("ab_reg", bus.register_data_debug, 32'h0);
        chk("ab_pclr", {30'h0, bus.rd_pending}, 32'h0);
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd29; bus.wr0_data = 32'h77;
        tick();
        idle_bus();
        #1;
        chk("ab_wr", bus.register_data_debug, 32'h77);
        chk("ab_busy2", {31'h0, bus.clear_busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
